// File: rtl/decode_pipe.sv
// RV32 decode stage: register file, immediate/type decode, one registered output slot.
// Latency: one cycle from accept to o_valid. Optional operand bypass under DECODE_BYPASS_EN.
// Backpressure: o_ready = !o_valid || i_ready, no skid buffer; a held slot keeps its outputs.
module decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_index,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [5:0]      o_type,
  output logic            o_illegal
);

  // RV32E only needs 4 index bits; higher indices are filtered by in_range()
  localparam int RW = (NUM_REGS == 16) ? 4 : 5;

  logic [XLEN-1:0] rf [NUM_REGS];
  logic            slot_vld;
  logic            accept;

  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic            t_r, t_i, t_s, t_b, t_u, t_j;
  logic [XLEN-1:0] d_imm;
  logic            d_ill;
  logic [XLEN-1:0] d_rs1_data, d_rs2_data;

  // x0 and indices beyond the architectural file are not real registers
  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NUM_REGS);
  endfunction

  // Gate the handshake with reset so neither side sees a transfer on the reset cycle
  assign o_valid = slot_vld && !i_rst;
  assign o_ready = !i_rst && (!slot_vld || i_ready);
  assign accept  = i_valid && o_ready;

  // Field extraction, type flags and immediate selection (I > S > B > U > J)
  always_comb begin
    d_rs1 = i_inst[19:15];
    d_rs2 = i_inst[24:20];
    d_rd  = i_inst[11:7];
    t_r   = (i_inst[6:4] == 3'b011) && !i_inst[2];
    t_i   = (!i_inst[5] && !i_inst[2]) || (i_inst[6:4] == 3'b111) || (i_inst[4:2] == 3'b001);
    t_s   = (i_inst[6:4] == 3'b010);
    t_b   = i_inst[6] && (i_inst[4:2] == 3'b000);
    t_u   = (i_inst[4:2] == 3'b101);
    t_j   = i_inst[3];
    d_imm = '0;
    if (t_i)
      d_imm = XLEN'($signed(i_inst[31:20]));
    else if (t_s)
      d_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
    else if (t_b)
      d_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
    else if (t_u)
      d_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
    else if (t_j)
      d_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
    d_ill = (i_inst[1:0] != 2'b11) ||
            ((NUM_REGS == 16) && (d_rs1[4] || d_rs2[4] || d_rd[4]));
  end

  // Operand read from pre-write array contents, optionally forwarding the same-cycle writeback
  always_comb begin
    d_rs1_data = '0;
    d_rs2_data = '0;
    if (in_range(d_rs1)) d_rs1_data = rf[d_rs1[RW-1:0]];
    if (in_range(d_rs2)) d_rs2_data = rf[d_rs2[RW-1:0]];
`ifdef DECODE_BYPASS_EN
    if (i_wb_en && in_range(d_rs1) && (i_wb_index == d_rs1)) d_rs1_data = i_wb_data;
    if (i_wb_en && in_range(d_rs2) && (i_wb_index == d_rs2)) d_rs2_data = i_wb_data;
`endif
  end

  // Output slot: flush beats accept, accept loads, otherwise drain when downstream takes it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_vld   <= 1'b0;
      o_pc       <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_imm      <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
      o_rd       <= '0;
      o_type     <= '0;
      o_illegal  <= 1'b0;
    end else begin
      if (i_flush) begin
        slot_vld <= 1'b0;
      end else if (accept) begin
        slot_vld   <= 1'b1;
        o_pc       <= i_pc;
        o_rs1_data <= d_rs1_data;
        o_rs2_data <= d_rs2_data;
        o_imm      <= d_imm;
        o_rs1      <= d_rs1;
        o_rs2      <= d_rs2;
        o_rd       <= d_rd;
        o_type     <= {t_j, t_u, t_b, t_s, t_i, t_r};
        o_illegal  <= d_ill;
      end else if (i_ready) begin
        slot_vld <= 1'b0;
      end
`ifdef DECODE_BYPASS_EN
      // A stalled instruction picks up writebacks to its sources so it never leaves stale
      if (slot_vld && !i_ready && !i_flush && i_wb_en) begin
        if (in_range(o_rs1) && (i_wb_index == o_rs1)) o_rs1_data <= i_wb_data;
        if (in_range(o_rs2) && (i_wb_index == o_rs2)) o_rs2_data <= i_wb_data;
      end
`endif
    end
  end

  // Register file: cleared on reset, writeback commits at the edge, x0/out-of-range ignored
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) rf[k] <= '0;
    end else if (i_wb_en && in_range(i_wb_index)) begin
      rf[i_wb_index[RW-1:0]] <= i_wb_data;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: an RV32I and an RV32E instance share one directed stimulus stream.
// A reference model of the stage runs beside them and is compared every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, flush, wb_en, rdy;
  logic [31:0] inst, pc, wb_data;
  logic [4:0]  wb_idx;

  logic        o_valid [2];
  logic        o_ready [2];
  logic [31:0] o_pc [2], o_rs1d [2], o_rs2d [2], o_imm [2];
  logic [4:0]  o_rs1 [2], o_rs2 [2], o_rd [2];
  logic [5:0]  o_type [2];
  logic        o_ill [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .NUM_REGS(32)) u_i (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[0]), .i_inst(inst), .i_pc(pc),
    .i_flush(flush), .i_wb_en(wb_en), .i_wb_index(wb_idx), .i_wb_data(wb_data),
    .o_valid(o_valid[0]), .i_ready(rdy), .o_pc(o_pc[0]), .o_rs1_data(o_rs1d[0]),
    .o_rs2_data(o_rs2d[0]), .o_imm(o_imm[0]), .o_rs1(o_rs1[0]), .o_rs2(o_rs2[0]),
    .o_rd(o_rd[0]), .o_type(o_type[0]), .o_illegal(o_ill[0]));

  decode_pipe #(.XLEN(32), .NUM_REGS(16)) u_e (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[1]), .i_inst(inst), .i_pc(pc),
    .i_flush(flush), .i_wb_en(wb_en), .i_wb_index(wb_idx), .i_wb_data(wb_data),
    .o_valid(o_valid[1]), .i_ready(rdy), .o_pc(o_pc[1]), .o_rs1_data(o_rs1d[1]),
    .o_rs2_data(o_rs2d[1]), .o_imm(o_imm[1]), .o_rs1(o_rs1[1]), .o_rs2(o_rs2[1]),
    .o_rd(o_rd[1]), .o_type(o_type[1]), .o_illegal(o_ill[1]));

  // ---------------- reference model ----------------
  logic [31:0] m_rf [2][32];
  logic        m_v [2] = '{1'b0, 1'b0};
  logic [31:0] m_pc [2], m_rs1d [2], m_rs2d [2], m_imm [2];
  logic [4:0]  m_rs1 [2], m_rs2 [2], m_rd [2];
  logic [5:0]  m_type [2];
  logic        m_ill [2];

  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic real_reg(input int k, input logic [4:0] idx);
    return (idx != 0) && (int'(idx) < nregs(k));
  endfunction

  function automatic logic [5:0] ref_type(input logic [31:0] w);
    logic r, i, s, b, u, j;
    r = (w[6:4] == 3'b011) && !w[2];
    i = (!w[5] && !w[2]) || (w[6:4] == 3'b111) || (w[4:2] == 3'b001);
    s = (w[6:4] == 3'b010);
    b = w[6] && (w[4:2] == 3'b000);
    u = (w[4:2] == 3'b101);
    j = w[3];
    return {j, u, b, s, i, r};
  endfunction

  // Immediates assembled by shifting fields into place over an all-ones/all-zeros sign word
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [5:0]  t;
    logic [31:0] sg;
    t  = ref_type(w);
    sg = w[31] ? 32'hFFFF_FFFF : 32'h0;
    if (t[1]) return (sg << 12) | 32'(w[31:20]);
    if (t[2]) return (sg << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
    if (t[3]) return (sg << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    if (t[4]) return w & 32'hFFFF_F000;
    if (t[5]) return (sg << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    return 32'h0;
  endfunction

  task automatic model_step(input int k);
    logic acc;
    if (rst) begin
      m_v[k] = 0; m_pc[k] = 0; m_rs1d[k] = 0; m_rs2d[k] = 0; m_imm[k] = 0;
      m_rs1[k] = 0; m_rs2[k] = 0; m_rd[k] = 0; m_type[k] = 0; m_ill[k] = 0;
      for (int i = 0; i < 32; i++) m_rf[k][i] = 0;
    end else begin
      acc = valid && (!m_v[k] || rdy);
`ifdef DECODE_BYPASS_EN
      if (m_v[k] && !rdy && !flush && wb_en) begin
        if (real_reg(k, m_rs1[k]) && wb_idx == m_rs1[k]) m_rs1d[k] = wb_data;
        if (real_reg(k, m_rs2[k]) && wb_idx == m_rs2[k]) m_rs2d[k] = wb_data;
      end
`endif
      if (flush) m_v[k] = 0;
      else if (acc) begin
        m_v[k]   = 1;
        m_pc[k]  = pc;
        m_rs1[k] = inst[19:15];
        m_rs2[k] = inst[24:20];
        m_rd[k]  = inst[11:7];
        m_rs1d[k] = real_reg(k, inst[19:15]) ? m_rf[k][inst[19:15]] : 32'h0;
        m_rs2d[k] = real_reg(k, inst[24:20]) ? m_rf[k][inst[24:20]] : 32'h0;
`ifdef DECODE_BYPASS_EN
        if (wb_en && real_reg(k, inst[19:15]) && wb_idx == inst[19:15]) m_rs1d[k] = wb_data;
        if (wb_en && real_reg(k, inst[24:20]) && wb_idx == inst[24:20]) m_rs2d[k] = wb_data;
`endif
        m_type[k] = ref_type(inst);
        m_imm[k]  = ref_imm(inst);
        m_ill[k]  = (inst[1:0] != 2'b11) ||
                    ((nregs(k) == 16) && (inst[19] || inst[24] || inst[11]));
      end else if (m_v[k] && rdy) m_v[k] = 0;
      if (wb_en && real_reg(k, wb_idx)) m_rf[k][wb_idx] = wb_data;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("valid", k, 32'(o_valid[k]), 32'(m_v[k] && !rst));
      chk("ready", k, 32'(o_ready[k]), 32'(!rst && (!m_v[k] || rdy)));
      if (m_v[k] && !rst) begin
        chk("pc", k, o_pc[k], m_pc[k]);
        chk("rs1d", k, o_rs1d[k], m_rs1d[k]);
        chk("rs2d", k, o_rs2d[k], m_rs2d[k]);
        chk("imm", k, o_imm[k], m_imm[k]);
        chk("idx", k, {17'h0, o_rs1[k], o_rs2[k], o_rd[k]}, {17'h0, m_rs1[k], m_rs2[k], m_rd[k]});
        chk("type", k, 32'(o_type[k]), 32'(m_type[k]));
        chk("ill", k, 32'(o_ill[k]), 32'(m_ill[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] a);
    inst = w; pc = a; valid = 1;
    cyc;
    valid = 0;
  endtask

  initial begin
    rst = 1; valid = 0; flush = 0; wb_en = 0; rdy = 1;
    inst = 0; pc = 0; wb_idx = 0; wb_data = 0;
    cyc; cyc;
    rst = 0;
    cyc;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_valid[k]), 0);
      chk("rst_ready", k, 32'(o_ready[k]), 1);
      chk("rst_imm", k, o_imm[k], 0);
      chk("rst_type", k, 32'(o_type[k]), 0);
    end

    // addi x1,x0,5
    issue(32'h0050_0093, 32'h100);
    for (int k = 0; k < 2; k++) begin
      chk("addi_valid", k, 32'(o_valid[k]), 1);
      chk("addi_type", k, 32'(o_type[k]), 32'b000010);
      chk("addi_imm", k, o_imm[k], 5);
      chk("addi_rd", k, 32'(o_rd[k]), 1);
      chk("addi_rs1d", k, o_rs1d[k], 0);
      chk("addi_ill", k, 32'(o_ill[k]), 0);
    end
    cyc;

    // x2 = DEADBEEF, x1 = 0x11, then bne x1,x2,-4
    wb_en = 1; wb_idx = 2; wb_data = 32'hDEAD_BEEF; cyc;
    wb_idx = 1; wb_data = 32'h11; cyc;
    wb_en = 0;
    issue(32'hFE20_9EE3, 32'h104);
    for (int k = 0; k < 2; k++) begin
      chk("bne_type", k, 32'(o_type[k]), 32'b001000);
      chk("bne_imm", k, o_imm[k], 32'hFFFF_FFFC);
      chk("bne_rs2d", k, o_rs2d[k], 32'hDEAD_BEEF);
      chk("bne_rs1d", k, o_rs1d[k], 32'h11);
    end
    cyc;

    // Stall three cycles with a new instruction waiting, then drain and accept together
    issue(32'h0050_0093, 32'h200);
    rdy = 0; inst = 32'h0020_81B3; pc = 32'h204; valid = 1;
    for (int n = 0; n < 3; n++) begin
      cyc;
      chk("stall_pc", 0, o_pc[0], 32'h200);
      chk("stall_ready", 0, 32'(o_ready[0]), 0);
    end
    rdy = 1;
    cyc;
    valid = 0;
    chk("drain_acc_valid", 0, 32'(o_valid[0]), 1);
    chk("drain_acc_pc", 0, o_pc[0], 32'h204);
    chk("drain_acc_type", 0, 32'(o_type[0]), 32'b000001);
    cyc;

    // add x3,x1,x2 with same-cycle writeback of x1, then writeback of x2 while stalled
    wb_en = 1; wb_idx = 1; wb_data = 32'h7;
    issue(32'h0020_81B3, 32'h300);
    wb_en = 0; rdy = 0;
`ifdef DECODE_BYPASS_EN
    chk("byp_rs1d", 0, o_rs1d[0], 32'h7);
`else
    chk("byp_rs1d", 0, o_rs1d[0], 32'h11);
`endif
    wb_en = 1; wb_idx = 2; wb_data = 32'h9;
    cyc;
    wb_en = 0;
`ifdef DECODE_BYPASS_EN
    chk("held_rs2d", 0, o_rs2d[0], 32'h9);
`else
    chk("held_rs2d", 0, o_rs2d[0], 32'hDEAD_BEEF);
`endif
    rdy = 1;
    cyc;

    // Flush against accept, then flush of a held slot
    flush = 1;
    issue(32'h0050_0093, 32'h400);
    flush = 0;
    chk("flush_acc", 0, 32'(o_valid[0]), 0);
    issue(32'h0050_0093, 32'h404);
    rdy = 0;
    chk("pre_flush", 0, 32'(o_valid[0]), 1);
    flush = 1;
    cyc;
    flush = 0;
    chk("flush_held", 0, 32'(o_valid[0]), 0);
    rdy = 1;

    // RV32E index limits
    issue(32'h0010_0893, 32'h500);       // addi x17,x0,1
    chk("e_ill17", 0, 32'(o_ill[0]), 0);
    chk("e_ill17", 1, 32'(o_ill[1]), 1);
    wb_en = 1; wb_idx = 20; wb_data = 32'h55; cyc;
    wb_en = 0;
    issue(32'h000A_0093, 32'h504);       // addi x1,x20,0
    chk("e_x20", 0, o_rs1d[0], 32'h55);
    chk("e_x20", 1, o_rs1d[1], 0);
    wb_en = 1; wb_idx = 0; wb_data = 32'h5; cyc;
    wb_en = 0;
    issue(32'h0000_0093, 32'h508);       // addi x1,x0,0
    chk("x0_read", 0, o_rs1d[0], 0);
    chk("x0_read", 1, o_rs1d[1], 0);

    // Other formats
    issue(32'h1234_52B7, 32'h600);       // lui x5,0x12345
    chk("lui_type", 0, 32'(o_type[0]), 32'b010000);
    chk("lui_imm", 0, o_imm[0], 32'h1234_5000);
    issue(32'h0020_A423, 32'h604);       // sw x2,8(x1)
    chk("sw_type", 0, 32'(o_type[0]), 32'b000100);
    chk("sw_imm", 0, o_imm[0], 32'h8);
    issue(32'hFF9F_F0EF, 32'h608);       // jal
    issue(32'h0050_0090, 32'h60C);       // low bits not 11
    chk("ill_op", 0, 32'(o_ill[0]), 1);
    chk("ill_op", 1, 32'(o_ill[1]), 1);
    cyc;

    // Reset while stalled: no handshake visible during reset
    issue(32'h0050_0093, 32'h700);
    rdy = 0;
    cyc;
    chk("pre_rst", 0, 32'(o_valid[0]), 1);
    rst = 1; rdy = 1;
    #1;
    chk("rst_stall_valid", 0, 32'(o_valid[0]), 0);
    chk("rst_stall_valid", 1, 32'(o_valid[1]), 0);
    cyc;
    rst = 0;
    #1;
    chk("post_rst_valid", 0, 32'(o_valid[0]), 0);
    chk("post_rst_pc", 0, o_pc[0], 0);
    cyc; cyc;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, registered successor to the single-cycle decode stage.
- Owns the integer register file, generates RV32 immediates and instruction-type flags, and registers all results into one output pipeline slot.
- Valid/ready handshake to fetch (upstream) and execute (downstream); flush input from branch resolution.
- Writeback port with optional same-cycle bypass and refresh of stalled operands.

Parameters:
- XLEN, 32, register/data/PC width (instruction width fixed at 32).
- NUM_REGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E) only.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept.
- i_inst  in  32  instruction.
- i_pc  in  XLEN  instruction address.
- i_flush  in  1  kill contents of the output slot.
- i_wb_en  in  1  writeback enable.
- i_wb_index  in  5  writeback register.
- i_wb_data  in  XLEN  writeback data.
- o_valid  out  1  output slot valid.
- i_ready  in  1  downstream accepts.
- o_pc  out  XLEN  registered PC.
- o_rs1_data  out  XLEN  operand 1.
- o_rs2_data  out  XLEN  operand 2.
- o_imm  out  XLEN  sign-extended immediate.
- o_rs1, o_rs2, o_rd  out  5 each  register indices.
- o_type  out  6  one-hot-ish type flags {J,U,B,S,I,R}, bit 0 = R.
- o_illegal  out  1  decode fault.

Behaviour:
- Reset (i_rst high at edge): o_valid=0; all other outputs 0; every register-file entry cleared to 0.
- o_ready = !o_valid || i_ready (combinational, no skid buffer).
- Accept when i_valid && o_ready: next edge loads the slot, o_valid=1. Latency is one cycle.
- Slot drains when o_valid && i_ready && !accept; o_valid goes 0.
- While o_valid && !i_ready, all outputs hold stable (except the refresh rule below).
- i_flush: next edge o_valid=0; this has priority over accept in the same cycle (the incoming instruction is dropped). Data fields may hold stale values.
- Fields:
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
  - R = inst[6:4]==011 && !inst[2].
  - I = (!inst[5] && !inst[2]) || inst[6:4]==111 || inst[4:2]==001.
  - S = inst[6:4]==010.
  - B = inst[6] && inst[4:2]==000.
  - U = inst[4:2]==101.
  - J = inst[3].
- Immediate, priority I>S>B>U>J, else 0:
  - I = sext(inst[31:20]).
  - S = sext({inst[31:25],inst[11:7]}).
  - B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U = {inst[31:12],12'b0}.
  - J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - Sign-extend to XLEN.
- o_illegal = inst[1:0]!=11, or (NUM_REGS==16 and any of rs1/rs2/rd has bit 4 set).
- Register file:
  - Index 0 reads 0; writes to index 0 are ignored.
  - Indices >= NUM_REGS read 0; writes to them are ignored.
  - Write commits at the edge when i_wb_en is high.
- Reads are sampled at the accept edge from array contents before that edge's write (bypass aside).
- Reset mid-stall: slot invalidated; downstream must not observe a handshake on the reset cycle.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined:
  - Accept with i_wb_en && i_wb_index==rs1 (nonzero, in range) loads i_wb_data into o_rs1_data; same for rs2.
  - While held (o_valid && !i_ready && !flush), a writeback matching o_rs1/o_rs2 (nonzero, in range) overwrites o_rs1_data/o_rs2_data at that edge.
- Undefined:
  - Operands are the pre-write array value.
  - Held operands never change.
  - Hazards are the hazard unit's responsibility.

Test Plan:
- Reset then accept 0x00500093 (addi x1,x0,5), i_ready=1 -> next cycle o_valid=1, o_type=000010, o_imm=5, o_rd=1, o_rs1_data=0, o_illegal=0.
- Write x2=0xDEADBEEF, later accept 0xFE209EE3 (bne x1,x2,-4) -> o_type B bit set, o_imm=0xFFFFFFFC, o_rs2_data=0xDEADBEEF.
- i_ready=0 for 3 cycles with o_valid=1, new i_valid held -> o_ready=0, outputs stable, no second accept; i_ready=1 -> drain plus accept in the same cycle.
- Accept with i_flush=1 in the same cycle -> o_valid=0 next cycle; o_valid=1 then i_flush -> o_valid=0 next edge.
- With DECODE_BYPASS_EN: accept add x3,x1,x2 while wb x1=7 -> o_rs1_data=7; stall, then wb x2=9 -> o_rs2_data becomes 9. Without the macro: o_rs1_data = old x1, o_rs2_data unchanged.
- NUM_REGS=16: accept addi x17,x0,1 -> o_illegal=1; wb to x20 then read x20 -> 0; wb x0=5 -> x0 reads 0.
